// File: rtl/core_control_fsm_if.sv
// Handshake and control bundle between the core sequencer and its surroundings.
// The master side is the sequencer; the slave side is the datapath/memory environment.
interface core_control_fsm_if #(
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      INSTRUCTION;
    logic             IMEM_RVALID;
    logic             IMEM_RREADY;
    logic             DMEM_RVALID;
    logic             DMEM_RREADY;
    logic             DMEM_BVALID;
    logic             DMEM_BREADY;
    logic             TAKE_BRANCH;
    logic             STALL_REQ;
    logic             TRAP_CLR;
    logic [31:0]      INSTR_Q;
    logic             C_INSTR_FETCH;
    logic             C_DECODE;
    logic             C_ALU;
    logic             C_CMEM;
    logic             C_BRANCH;
    logic             C_DOLOAD;
    logic             C_DOSTORE;
    logic             C_PC_UPDATE;
    logic             C_REG_AWVALID;
    logic [3:0]       C_WB_CODE;
    logic             TRAP;
    logic [1:0]       TRAP_CAUSE;
    logic [2:0]       STATE;
    logic [CNT_W-1:0] RETIRED;

    modport master (
        input  INSTRUCTION, IMEM_RVALID, IMEM_RREADY, DMEM_RVALID, DMEM_RREADY,
               DMEM_BVALID, DMEM_BREADY, TAKE_BRANCH, STALL_REQ, TRAP_CLR,
        output INSTR_Q, C_INSTR_FETCH, C_DECODE, C_ALU, C_CMEM, C_BRANCH,
               C_DOLOAD, C_DOSTORE, C_PC_UPDATE, C_REG_AWVALID, C_WB_CODE,
               TRAP, TRAP_CAUSE, STATE, RETIRED
    );

    modport slave (
        output INSTRUCTION, IMEM_RVALID, IMEM_RREADY, DMEM_RVALID, DMEM_RREADY,
               DMEM_BVALID, DMEM_BREADY, TAKE_BRANCH, STALL_REQ, TRAP_CLR,
        input  INSTR_Q, C_INSTR_FETCH, C_DECODE, C_ALU, C_CMEM, C_BRANCH,
               C_DOLOAD, C_DOSTORE, C_PC_UPDATE, C_REG_AWVALID, C_WB_CODE,
               TRAP, TRAP_CAUSE, STATE, RETIRED
    );
endinterface

// File: rtl/core_control_fsm.sv
// Multi-cycle RV32I sequencer: IFETCH -> IDECODE -> EXEC -> MEM -> WB,
// with handshake timeouts, an illegal-opcode trap, fetch stall and retire counter.
module core_control_fsm #(
    parameter int unsigned IMEM_TIMEOUT = 16,
    parameter int unsigned DMEM_TIMEOUT = 16,
    parameter int unsigned TO_W         = 8,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    core_control_fsm_if.master bus
);
    typedef enum logic [2:0] {
        S_IFETCH  = 3'd0,
        S_IDECODE = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_t;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [TO_W-1:0] IMEM_LAST = TO_W'((IMEM_TIMEOUT == 0) ? 0 : IMEM_TIMEOUT - 1);
    localparam logic [TO_W-1:0] DMEM_LAST = TO_W'((DMEM_TIMEOUT == 0) ? 0 : DMEM_TIMEOUT - 1);
    localparam logic            IMEM_TO_EN = (IMEM_TIMEOUT != 0);
    localparam logic            DMEM_TO_EN = (DMEM_TIMEOUT != 0);

    state_t           r_state;
    logic [31:0]      r_instr;
    logic [TO_W-1:0]  r_to_cnt;
    logic [1:0]       r_cause;
    logic             r_brflag;
    logic [CNT_W-1:0] r_retired;
    logic             r_decode, r_alu, r_cmem, r_branch, r_doload, r_dostore;
    logic             r_pc_update, r_reg_awvalid, r_trap;
    logic [3:0]       r_wb_code;

    state_t           w_next_state;
    logic [31:0]      w_next_instr;
    logic [TO_W-1:0]  w_next_cnt;
    logic [1:0]       w_next_cause;
    logic             w_next_brflag;
    logic [CNT_W-1:0] w_next_retired;
    logic             w_decode, w_alu, w_cmem, w_branch, w_doload, w_dostore;
    logic             w_pc_update, w_reg_awvalid, w_trap;
    logic [3:0]       w_wb_code;

    logic [6:0] w_op;
    logic       w_is_alu, w_is_load, w_is_store, w_is_branch;
    logic       w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_is_fence;
    logic       w_fetch_hs, w_mem_hs;

    assign w_op        = r_instr[6:0];
    assign w_is_alu    = (w_op == OP_R) || (w_op == OP_IALU);
    assign w_is_load   = (w_op == OP_LOAD);
    assign w_is_store  = (w_op == OP_STORE);
    assign w_is_branch = (w_op == OP_BRANCH);
    assign w_is_jal    = (w_op == OP_JAL);
    assign w_is_jalr   = (w_op == OP_JALR);
    assign w_is_lui    = (w_op == OP_LUI);
    assign w_is_auipc  = (w_op == OP_AUIPC);
    assign w_is_fence  = (w_op == OP_FENCE);

    assign w_fetch_hs = bus.IMEM_RVALID & bus.IMEM_RREADY & ~bus.STALL_REQ;
    assign w_mem_hs   = w_is_load ? (bus.DMEM_RVALID & bus.DMEM_RREADY)
                                  : (bus.DMEM_BVALID & bus.DMEM_BREADY);

    // Next-state, timeout counter, instruction latch and retire counter update.
    always_comb begin
        w_next_state   = r_state;
        w_next_instr   = r_instr;
        w_next_cnt     = r_to_cnt;
        w_next_cause   = r_cause;
        w_next_brflag  = r_brflag;
        w_next_retired = r_retired;
        case (r_state)
            S_IFETCH: begin
                if (!bus.STALL_REQ) begin
                    if (w_fetch_hs) begin
                        w_next_instr = bus.INSTRUCTION;
                        w_next_cnt   = '0;
                        w_next_state = S_IDECODE;
                    end else if (IMEM_TO_EN && (r_to_cnt == IMEM_LAST)) begin
                        w_next_cause = 2'd2;
                        w_next_state = S_TRAP;
                    end else begin
                        w_next_cnt = r_to_cnt + TO_W'(1);
                    end
                end
            end
            S_IDECODE: begin
                if (w_is_jal || w_is_jalr || w_is_lui || w_is_auipc || w_is_fence) begin
                    w_next_state = S_WB;
                end else if (w_is_alu || w_is_load || w_is_store || w_is_branch) begin
                    w_next_state = S_EXEC;
                end else begin
                    w_next_cause = 2'd1;
                    w_next_state = S_TRAP;
                end
            end
            S_EXEC: begin
                if (w_is_branch) begin
                    w_next_brflag = bus.TAKE_BRANCH;
                end
                w_next_state = (w_is_load || w_is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (w_mem_hs) begin
                    w_next_cnt   = '0;
                    w_next_state = S_WB;
                end else if (DMEM_TO_EN && (r_to_cnt == DMEM_LAST)) begin
                    w_next_cause = 2'd3;
                    w_next_state = S_TRAP;
                end else begin
                    w_next_cnt = r_to_cnt + TO_W'(1);
                end
            end
            S_WB: begin
                w_next_retired = r_retired + CNT_W'(1);
                w_next_state   = S_IFETCH;
            end
            S_TRAP: begin
                if (bus.TRAP_CLR) begin
                    w_next_cause = 2'd0;
                    w_next_cnt   = '0;
                    w_next_state = S_IFETCH;
                end
            end
            default: w_next_state = S_IFETCH;
        endcase
    end

    // Strobes for the state being entered; the opcode only changes on entry to
    // IDECODE, whose strobe is opcode-independent, so r_instr decode is valid here.
    // Registering this gives flop outputs identical in timing to decoding STATE.
    always_comb begin
        w_decode      = 1'b0;
        w_alu         = 1'b0;
        w_cmem        = 1'b0;
        w_branch      = 1'b0;
        w_doload      = 1'b0;
        w_dostore     = 1'b0;
        w_pc_update   = 1'b0;
        w_reg_awvalid = 1'b0;
        w_trap        = 1'b0;
        w_wb_code     = 4'd0;
        case (w_next_state)
            S_IDECODE: w_decode = 1'b1;
            S_EXEC: begin
                w_alu    = w_is_alu;
                w_cmem   = w_is_load | w_is_store;
                w_branch = w_is_branch;
            end
            S_MEM: begin
                w_doload  = w_is_load;
                w_dostore = w_is_store;
            end
            S_WB: begin
                w_pc_update = 1'b1;
                if (w_is_alu) begin
                    w_wb_code = 4'd1; w_reg_awvalid = 1'b1;
                end else if (w_is_branch) begin
                    w_wb_code = w_next_brflag ? 4'd2 : 4'd0;
                end else if (w_is_load) begin
                    w_wb_code = 4'd3; w_reg_awvalid = 1'b1;
                end else if (w_is_jal) begin
                    w_wb_code = 4'd4; w_reg_awvalid = 1'b1;
                end else if (w_is_jalr) begin
                    w_wb_code = 4'd5; w_reg_awvalid = 1'b1;
                end else if (w_is_lui) begin
                    w_wb_code = 4'd6; w_reg_awvalid = 1'b1;
                end else if (w_is_auipc) begin
                    w_wb_code = 4'd7; w_reg_awvalid = 1'b1;
                end
            end
            S_TRAP: w_trap = 1'b1;
            default: ;
        endcase
    end

    // State register, datapath latches and registered control strobes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= S_IFETCH;
            r_instr       <= '0;
            r_to_cnt      <= '0;
            r_cause       <= '0;
            r_brflag      <= 1'b0;
            r_retired     <= '0;
            r_decode      <= 1'b0;
            r_alu         <= 1'b0;
            r_cmem        <= 1'b0;
            r_branch      <= 1'b0;
            r_doload      <= 1'b0;
            r_dostore     <= 1'b0;
            r_pc_update   <= 1'b0;
            r_reg_awvalid <= 1'b0;
            r_trap        <= 1'b0;
            r_wb_code     <= '0;
        end else begin
            r_state       <= w_next_state;
            r_instr       <= w_next_instr;
            r_to_cnt      <= w_next_cnt;
            r_cause       <= w_next_cause;
            r_brflag      <= w_next_brflag;
            r_retired     <= w_next_retired;
            r_decode      <= w_decode;
            r_alu         <= w_alu;
            r_cmem        <= w_cmem;
            r_branch      <= w_branch;
            r_doload      <= w_doload;
            r_dostore     <= w_dostore;
            r_pc_update   <= w_pc_update;
            r_reg_awvalid <= w_reg_awvalid;
            r_trap        <= w_trap;
            r_wb_code     <= w_wb_code;
        end
    end

    assign bus.C_INSTR_FETCH = (r_state == S_IFETCH) & ~bus.STALL_REQ & ~RST;
    assign bus.INSTR_Q       = r_instr;
    assign bus.C_DECODE      = r_decode;
    assign bus.C_ALU         = r_alu;
    assign bus.C_CMEM        = r_cmem;
    assign bus.C_BRANCH      = r_branch;
    assign bus.C_DOLOAD      = r_doload;
    assign bus.C_DOSTORE     = r_dostore;
    assign bus.C_PC_UPDATE   = r_pc_update;
    assign bus.C_REG_AWVALID = r_reg_awvalid;
    assign bus.C_WB_CODE     = r_wb_code;
    assign bus.TRAP          = r_trap;
    assign bus.TRAP_CAUSE    = r_cause;
    assign bus.STATE         = r_state;
    assign bus.RETIRED       = r_retired;
endmodule
